// File: rtl/score_pkg.sv
// Shared widths, FSM states and the digit bundle for the score display path.
package score_pkg;
  localparam int SCORE_W       = 14;
  localparam int DIGIT_W       = 4;
  localparam int BCD_ITERS     = 14;
  localparam int SCORE_MAX_DEF = 9999;

  typedef enum logic [1:0] {IDLE, ADD, CONVERT} score_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] thousands;
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } digits_t;
endpackage

// File: rtl/score_controller_bin2bcd_seq.sv
// Sequential double-dabble: one adjust+shift per cycle, BCD_ITERS cycles per conversion.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               abort,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output digits_t            bcd
);
  localparam int SR_W = SCORE_W + 4 * DIGIT_W;

  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_adj;
  logic [SR_W-1:0] sr_nxt;
  logic [3:0]      cnt;
  logic            running;

  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 4; k++) begin
      if (sr[SCORE_W + k*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
        sr_adj[SCORE_W + k*DIGIT_W +: DIGIT_W] = sr[SCORE_W + k*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
    end
    sr_nxt = sr_adj << 1;
  end

  // done and bcd reflect the shift being performed this cycle, so the
  // caller can capture the final digits on the same edge as the last shift.
  assign done = running && (cnt == 4'(BCD_ITERS - 1));
  assign bcd  = digits_t'(sr_nxt[SR_W-1 -: 4*DIGIT_W]);

  always_ff @(posedge Clk) begin
    if (!reset_n || abort) begin
      sr      <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      sr      <= {{(4*DIGIT_W){1'b0}}, bin};
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      sr  <= sr_nxt;
      cnt <= cnt + 4'd1;
      if (done)
        running <= 1'b0;
    end
  end
endmodule

// File: rtl/score_controller.sv
// Round-robin award arbiter, saturating score accumulator and BCD digit sequencer.
// state   | meaning
// IDLE    | waiting for a request; grant is driven combinationally here
// ADD     | accumulate latched award into score with saturation
// CONVERT | 14-cycle binary-to-BCD conversion; digits hold old value
module score_controller
  import score_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PTS_W     = 8,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PTS_W-1:0] points,
  output logic [N_REQ-1:0]       grant,
  output logic [SCORE_W-1:0]     score,
  output logic [DIGIT_W-1:0]     thousands,
  output logic [DIGIT_W-1:0]     hundreds,
  output logic [DIGIT_W-1:0]     tens,
  output logic [DIGIT_W-1:0]     ones,
  output logic                   digits_valid,
  output logic                   busy
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  score_state_t     state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand;
  logic             found;
  logic [PTS_W-1:0] pts_q;
  logic [SCORE_W:0] sum_w;
  logic [SCORE_W-1:0] score_add;
  logic             clr_pend;
  logic             cvt_start;
  logic             cvt_done;
  digits_t          digits;
  digits_t          cvt_bcd;

  always_comb begin
    win   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && !clear && found)
      grant[win] = 1'b1;
  end

  // Sum is one bit wider than the score so the ceiling compare sees overflow.
  assign sum_w     = {1'b0, score} + (SCORE_W+1)'(pts_q);
  assign score_add = (sum_w > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                        : sum_w[SCORE_W-1:0];
  assign cvt_start = (state == ADD) && !clear;

  bin2bcd_seq u_bin2bcd (
    .Clk     (Clk),
    .reset_n (reset_n),
    .abort   (clear),
    .start   (cvt_start),
    .bin     (score_add),
    .done    (cvt_done),
    .bcd     (cvt_bcd)
  );

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= PTR_W'(N_REQ - 1);
      pts_q        <= '0;
      score        <= '0;
      digits       <= '0;
      clr_pend     <= 1'b0;
      digits_valid <= 1'b0;
    end else begin
      clr_pend     <= clear;
      digits_valid <= clr_pend;
      if (clear) begin
        state  <= IDLE;
        score  <= '0;
        digits <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              pts_q <= points[int'(win)*PTS_W +: PTS_W];
              ptr   <= win;
              state <= ADD;
            end
          end
          ADD: begin
            score <= score_add;
            state <= CONVERT;
          end
          CONVERT: begin
            if (cvt_done) begin
              digits       <= cvt_bcd;
              digits_valid <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign thousands = digits.thousands;
  assign hundreds  = digits.hundreds;
  assign tens      = digits.tens;
  assign ones      = digits.ones;
endmodule
